// File: rtl/edulent_mem.sv
// Single-port 256x8 memory with boot-time zero-fill and a host program loader.
// Latency: 0-cycle combinational read; writes land at the sampling edge; loader takes 1 byte/cycle.
// Backpressure: o_load_ready is high only while loading; the CPU is held in reset until an image is loaded.
module edulent_mem #(
    parameter int DEPTH = 256
) (
    input  logic       i_clk,
    input  logic       i_rstn,
    input  logic [7:0] i_mem_addr,
    input  logic       i_mem_write_enable,
    input  logic [7:0] i_mem_data_write,
    output logic [7:0] o_mem_data_read,
    input  logic       i_load_start,
    input  logic [7:0] i_load_len,
    input  logic       i_load_valid,
    input  logic [7:0] i_load_data,
    output logic       o_load_ready,
    output logic       o_load_done,
    output logic       o_cpu_rstn,
    output logic       o_busy
);

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_HOLD  = 2'd1,
        S_LOAD  = 2'd2,
        S_RUN   = 2'd3
    } state_t;

    state_t     state;
    logic [7:0] clr_ptr;
    logic [7:0] load_ptr;
    logic [8:0] count;
    logic [7:0] mem [DEPTH];

    logic       load_fire;
    logic [8:0] len_ext;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_dat;

    // A length field of zero stands for a full 256-byte image.
    assign len_ext      = (i_load_len == 8'd0) ? 9'd256 : {1'b0, i_load_len};
    assign o_load_ready = (state == S_LOAD);
    assign load_fire    = o_load_ready && i_load_valid;
    assign o_busy       = (state != S_RUN);
    assign o_mem_data_read = (state == S_RUN) ? mem[i_mem_addr] : 8'h00;

    // Select the single write source for this cycle from the current state.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = i_mem_addr;
        wr_dat  = i_mem_data_write;
        case (state)
            S_CLEAR: begin
                wr_en   = 1'b1;
                wr_addr = clr_ptr;
                wr_dat  = 8'h00;
            end
            S_LOAD: begin
                wr_en   = load_fire;
                wr_addr = load_ptr;
                wr_dat  = i_load_data;
            end
            S_RUN: begin
                wr_en   = i_mem_write_enable;
            end
            default: begin
                wr_en   = 1'b0;
            end
        endcase
    end

    // Storage array; contents are initialised by the CLEAR sweep, not by reset.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_dat;
        end
    end

    // Control FSM with registered done pulse and CPU reset.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state       <= S_CLEAR;
            clr_ptr     <= 8'd0;
            load_ptr    <= 8'd0;
            count       <= 9'd0;
            o_load_done <= 1'b0;
            o_cpu_rstn  <= 1'b0;
        end else begin
            o_load_done <= 1'b0;
            o_cpu_rstn  <= (state == S_RUN);
            case (state)
                S_CLEAR: begin
                    clr_ptr <= clr_ptr + 8'd1;
                    if (clr_ptr == 8'hFF) begin
                        state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (i_load_start) begin
                        count    <= len_ext;
                        load_ptr <= 8'd0;
                        state    <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (load_fire) begin
                        load_ptr <= load_ptr + 8'd1;
                        count    <= count - 9'd1;
                        if (count == 9'd1) begin
                            state       <= S_RUN;
                            o_load_done <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    // A CPU write on this same edge still lands via the array block.
                    if (i_load_start) begin
                        count    <= len_ext;
                        load_ptr <= 8'd0;
                        state    <= S_LOAD;
                    end
                end
                default: begin
                    state <= S_CLEAR;
                end
            endcase
        end
    end

endmodule

// File: doc/edulent_mem.md
# edulent_mem

Single-port 256×8 memory and program loader that answers the Edulent data path's memory interface.
- The data path drives an address, write data and write enable; this block returns read data on the same cycle.
- After reset it zero-fills the array, then holds the CPU in reset until a host loads a program image over a valid/ready byte stream.
- It then releases the CPU and serves its reads and writes.
- It sits between the data path, the top level and the host/loader link.

## Interface
Parameters:
- DEPTH, 256, number of bytes. Fixed to 2^8 because the address is 8 bits.

Ports:
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rstn  in  1  asynchronous, active-low reset.
- i_mem_addr  in  8  CPU address (the data path's MA).
- i_mem_write_enable  in  1  CPU write strobe.
- i_mem_data_write  in  8  CPU write data.
- o_mem_data_read  out  8  CPU read data, combinational.
- i_load_start  in  1  request to (re)load a program image.
- i_load_len  in  8  image length in bytes; 0 means 256.
- i_load_valid  in  1  loader byte valid.
- i_load_data  in  8  loader byte.
- o_load_ready  out  1  block accepts a loader byte this cycle.
- o_load_done  out  1  one-cycle pulse after the last image byte is written.
- o_cpu_rstn  out  1  active-low reset to the data path and control unit, registered.
- o_busy  out  1  high in every state except RUN.

## Operation
- States: CLEAR, HOLD, LOAD, RUN. Async reset enters CLEAR with clr_ptr=0.
- CLEAR:
  - Each cycle writes mem[clr_ptr]=0x00 and increments clr_ptr.
  - After writing address 255, goes to HOLD. CLEAR takes 256 cycles.
  - i_load_start is ignored in CLEAR; it is not queued.
- HOLD: i_load_start=1 captures len (0→256) into a 9-bit count, sets load_ptr=0 and goes to LOAD.
- LOAD:
  - o_load_ready=1.
  - Each cycle with i_load_valid&&o_load_ready: mem[load_ptr]=i_load_data, load_ptr++ (8-bit, wraps 255→0), count--.
  - Accepting the byte that takes count to 0 moves to RUN and pulses o_load_done.
  - i_load_start during LOAD is ignored.
- RUN:
  - o_cpu_rstn=1.
  - i_mem_write_enable=1 writes mem[i_mem_addr]=i_mem_data_write at the edge.
  - i_load_start=1 re-enters LOAD, captures a new length and clears load_ptr. The CPU is held again; memory is not cleared.
- o_mem_data_read:
  - In RUN it is mem[i_mem_addr], asynchronous read.
  - Outside RUN it is 0x00.
- CPU writes outside RUN are ignored. The CPU is in reset then, so no such writes are expected.
- Simultaneous i_load_start and i_mem_write_enable in RUN: the CPU write completes at that edge, then the state moves to LOAD.
- Reset mid-LOAD or mid-RUN: returns to CLEAR and the whole array is re-zeroed. A partial image is discarded.
- o_cpu_rstn = registered (state==RUN). It rises one cycle after entering RUN and falls one cycle after leaving RUN.

## Timing
- Reset values:
  - o_cpu_rstn=0, o_load_ready=0, o_load_done=0, o_busy=1, o_mem_data_read=0x00.
  - Pointers and count are 0; state is CLEAR.
- Read latency is 0 cycles. A data path that registers MA at edge t and samples read data at edge t+1 sees mem[MA].
- Write takes effect at the edge where the enable is sampled high.
  - A read of the same address in the same cycle returns the old value.
  - From the next cycle the read returns the new value.
- Loader throughput is 1 byte/cycle. o_load_ready is decoded from state and is low the cycle after the final byte.
- From reset release, the earliest cycle o_load_ready=1 is cycle 257: 256 CLEAR cycles plus 1 HOLD cycle with start asserted.
- o_load_done is high for exactly the one cycle in which the state is first RUN.
- o_cpu_rstn rises the cycle after that.

## Test plan
- Reset, then wait 256 cycles, then force RUN via a 0-length-safe load of 1 byte 0xAA. Required:
  - addr 0 reads 0xAA.
  - Addresses 1..255 read 0x00.
  - o_load_done pulses once.
  - o_cpu_rstn rises one cycle after the pulse.
- Load 4 bytes 0x11,0x22,0x33,0x44 with i_load_valid toggled every other cycle. Required:
  - mem[0..3] equals those bytes; mem[4]=0x00.
  - Exactly 4 handshakes occur.
  - o_load_ready falls after the fourth.
- Load with i_load_len=0 and 256 bytes of value (i^0x5A). Required:
  - All 256 locations hold i^0x5A.
  - load_ptr wraps to 0.
  - A 257th valid byte is not accepted.
- In RUN, write 0x7E to address 0x40 with the same-cycle read at 0x40. Required:
  - The same-cycle read returns the old value.
  - The next cycle returns 0x7E.
- In RUN, assert i_load_start together with a CPU write of 0x99 to 0x10. Required:
  - mem[0x10]=0x99.
  - o_cpu_rstn goes low next cycle.
  - A 2-byte reload overwrites only mem[0..1].
- Assert i_rstn low after 2 of 8 load bytes. Required:
  - All outputs return to reset values immediately.
  - After CLEAR, mem[0..1] reads 0x00 once RUN is re-reached.
